// File: rtl/iob_wb_bridge_fsm_pkg.sv
// Shared definitions for the IOb-to-Wishbone bridge: state encodings and
// the read byte-select helper.
package iob_wb_bridge_fsm_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUS  = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   // Widest supported bus is 64 bits, so a byte-select never exceeds 8 bits.
   localparam int MAX_BYTES = 8;

   // Byte select for a read: a READ_BYTES-wide run of ones, aligned down to a
   // multiple of READ_BYTES inside the data word addressed by byte_addr.
   function automatic logic [MAX_BYTES-1:0] read_sel(input int data_bytes,
                                                     input int read_bytes,
                                                     input logic [7:0] byte_addr);
      int offset;
      offset = int'(byte_addr) % data_bytes;
      offset = offset & ~(read_bytes - 1);
      return MAX_BYTES'(((1 << read_bytes) - 1) << offset);
   endfunction

endpackage

// File: rtl/iob_wb_bridge_fsm_watchdog.sv
// Bus watchdog for the IOb-to-Wishbone bridge. Only present when
// IOB_WB_BRIDGE_TIMEOUT_EN is defined; otherwise this file is empty.
`ifdef IOB_WB_BRIDGE_TIMEOUT_EN
module iob_wb_watchdog #(
   parameter int WIDTH = 8
) (
   input  logic clk_i,
   input  logic arst_i,
   input  logic clear_i,
   input  logic enable_i,
   output logic expire_o
);

   // Last count before the counter would reach all-ones; hitting it while
   // enabled means the all-ones value is reached on this edge.
   localparam logic [WIDTH-1:0] LAST = ~(WIDTH'(1));

   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_d;

   // Clear wins over counting so a fresh bus cycle always starts from zero.
   always_comb begin
      count_d = count_q;
      if (clear_i) begin
         count_d = '0;
      end else if (enable_i) begin
         count_d = count_q + 1'b1;
      end
   end

   assign expire_o = enable_i && (count_q == LAST);

   // Counter register.
   always_ff @(posedge clk_i or posedge arst_i) begin
      if (arst_i) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule
`endif

// File: rtl/iob_wb_bridge_fsm.sv
// IOb-native slave to Wishbone classic master bridge. Captures one request,
// holds the Wishbone cycle until ack/err (or timeout) and returns a one-cycle
// registered response. Optional bus watchdog: IOB_WB_BRIDGE_TIMEOUT_EN.
module iob_wb_bridge_fsm
   import iob_wb_bridge_fsm_pkg::*;
#(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int READ_BYTES = 4,
   parameter int TIMEOUT_W  = 8
) (
   input  logic                  clk_i,
   input  logic                  arst_i,
   input  logic                  valid_i,
   input  logic [ADDR_W-1:0]     addr_i,
   input  logic [DATA_W-1:0]     wdata_i,
   input  logic [DATA_W/8-1:0]   wstrb_i,
   output logic [DATA_W-1:0]     rdata_o,
   output logic                  ready_o,
   output logic                  err_o,
   output logic                  busy_o,
   output logic [ADDR_W-1:0]     wb_adr_o,
   output logic [DATA_W/8-1:0]   wb_sel_o,
   output logic                  wb_we_o,
   output logic                  wb_cyc_o,
   output logic                  wb_stb_o,
   output logic [DATA_W-1:0]     wb_dat_o,
   input  logic                  wb_ack_i,
   input  logic [DATA_W-1:0]     wb_dat_i,
   input  logic                  wb_err_i
);

   localparam int NB = DATA_W / 8;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] adr_q, adr_d;
   logic [NB-1:0]     sel_q, sel_d;
   logic              we_q, we_d;
   logic [DATA_W-1:0] dat_q, dat_d;
   logic              cyc_q, cyc_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              err_q, err_d;
   logic              ready_q, ready_d;
   logic              busy_q, busy_d;
   logic [NB-1:0]     rd_sel;
   logic              timeout;

   assign rd_sel = NB'(read_sel(NB, READ_BYTES, 8'(addr_i)));

`ifdef IOB_WB_BRIDGE_TIMEOUT_EN
   logic wd_clear;
   logic wd_enable;

   assign wd_clear  = (state_q == ST_IDLE) && valid_i;
   assign wd_enable = (state_q == ST_BUS);

   iob_wb_watchdog #(
      .WIDTH(TIMEOUT_W)
   ) u_watchdog (
      .clk_i   (clk_i),
      .arst_i  (arst_i),
      .clear_i (wd_clear),
      .enable_i(wd_enable),
      .expire_o(timeout)
   );
`else
   assign timeout = 1'b0;
`endif

   // Next-state and next-output logic; every output is registered from here.
   always_comb begin
      state_d = state_q;
      adr_d   = adr_q;
      sel_d   = sel_q;
      we_d    = we_q;
      dat_d   = dat_q;
      cyc_d   = cyc_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      ready_d = 1'b0;
      busy_d  = busy_q;
      case (state_q)
         ST_IDLE: begin
            if (valid_i) begin
               adr_d   = addr_i;
               dat_d   = wdata_i;
               we_d    = |wstrb_i;
               sel_d   = (|wstrb_i) ? wstrb_i : rd_sel;
               cyc_d   = 1'b1;
               busy_d  = 1'b1;
               state_d = ST_BUS;
            end
         end
         ST_BUS: begin
            if (wb_ack_i || wb_err_i) begin
               rdata_d = we_q ? '0 : wb_dat_i;
               err_d   = wb_err_i;
               cyc_d   = 1'b0;
               ready_d = 1'b1;
               state_d = ST_RESP;
            end else if (timeout) begin
               rdata_d = '0;
               err_d   = 1'b1;
               cyc_d   = 1'b0;
               ready_d = 1'b1;
               state_d = ST_RESP;
            end
         end
         ST_RESP: begin
            rdata_d = '0;
            err_d   = 1'b0;
            busy_d  = 1'b0;
            state_d = ST_IDLE;
         end
         default: begin
            rdata_d = '0;
            err_d   = 1'b0;
            cyc_d   = 1'b0;
            busy_d  = 1'b0;
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and output registers; reset abandons any open Wishbone cycle.
   always_ff @(posedge clk_i or posedge arst_i) begin
      if (arst_i) begin
         state_q <= ST_IDLE;
         adr_q   <= '0;
         sel_q   <= '0;
         we_q    <= 1'b0;
         dat_q   <= '0;
         cyc_q   <= 1'b0;
         rdata_q <= '0;
         err_q   <= 1'b0;
         ready_q <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         adr_q   <= adr_d;
         sel_q   <= sel_d;
         we_q    <= we_d;
         dat_q   <= dat_d;
         cyc_q   <= cyc_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
         ready_q <= ready_d;
         busy_q  <= busy_d;
      end
   end

   assign rdata_o  = rdata_q;
   assign ready_o  = ready_q;
   assign err_o    = err_q;
   assign busy_o   = busy_q;
   assign wb_adr_o = adr_q;
   assign wb_sel_o = sel_q;
   assign wb_we_o  = we_q;
   assign wb_cyc_o = cyc_q;
   assign wb_stb_o = cyc_q;
   assign wb_dat_o = dat_q;

endmodule

// File: tb/tb_iob_wb_bridge_fsm.sv
// Testbench for iob_wb_bridge_fsm (DATA_W=32, READ_BYTES=1, TIMEOUT_W=4).
// Timeout scenario adapts to IOB_WB_BRIDGE_TIMEOUT_EN.
module tb_iob_wb_bridge_fsm;

   localparam int NB = 4;
   localparam int RB = 1;
   localparam int TW = 4;

   logic        clk_i, arst_i, valid_i;
   logic [31:0] addr_i, wdata_i;
   logic [3:0]  wstrb_i;
   logic [31:0] rdata_o;
   logic        ready_o, err_o, busy_o;
   logic [31:0] wb_adr_o;
   logic [3:0]  wb_sel_o;
   logic        wb_we_o, wb_cyc_o, wb_stb_o;
   logic [31:0] wb_dat_o;
   logic        wb_ack_i, wb_err_i;
   logic [31:0] wb_dat_i;

   int checks = 0;
   int errors = 0;

   iob_wb_bridge_fsm #(
      .ADDR_W(32), .DATA_W(32), .READ_BYTES(RB), .TIMEOUT_W(TW)
   ) dut (
      .clk_i(clk_i), .arst_i(arst_i), .valid_i(valid_i), .addr_i(addr_i),
      .wdata_i(wdata_i), .wstrb_i(wstrb_i), .rdata_o(rdata_o), .ready_o(ready_o),
      .err_o(err_o), .busy_o(busy_o), .wb_adr_o(wb_adr_o), .wb_sel_o(wb_sel_o),
      .wb_we_o(wb_we_o), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o),
      .wb_dat_o(wb_dat_o), .wb_ack_i(wb_ack_i), .wb_dat_i(wb_dat_i),
      .wb_err_i(wb_err_i)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   // Reference: byte b is read when it lies in the same READ_BYTES-sized
   // group as the addressed byte within the word.
   function automatic logic [3:0] model_read_sel(input logic [31:0] a);
      logic [3:0] s;
      int off;
      s = '0;
      off = int'(a % NB);
      for (int b = 0; b < NB; b++) begin
         if ((b / RB) == (off / RB)) s[b] = 1'b1;
      end
      return s;
   endfunction

   // One complete transfer starting at a negedge in IDLE; ends at the negedge
   // of the following IDLE cycle so calls chain back-to-back.
   task automatic do_transfer(input string tag, input logic [31:0] a, input logic [31:0] wd,
                              input logic [3:0] ws, input int delay, input logic ack,
                              input logic er, input logic [31:0] rd, input logic valid_in_bus);
      logic        exp_we;
      logic [3:0]  exp_sel;
      logic [31:0] exp_rdata;
      exp_we    = (ws != 4'h0);
      exp_sel   = exp_we ? ws : model_read_sel(a);
      exp_rdata = exp_we ? 32'h0 : rd;
      valid_i = 1'b1; addr_i = a; wdata_i = wd; wstrb_i = ws;
      @(negedge clk_i);
      valid_i = valid_in_bus; addr_i = $urandom; wdata_i = $urandom; wstrb_i = 4'($urandom);
      checks++;
      if ({wb_cyc_o, wb_stb_o, wb_we_o, busy_o, ready_o} !== {1'b1, 1'b1, exp_we, 1'b1, 1'b0}) begin
         errors++;
         $display("[TB] FAIL %s bus_ctrl got %b expected %b", tag,
                  {wb_cyc_o, wb_stb_o, wb_we_o, busy_o, ready_o}, {1'b1, 1'b1, exp_we, 1'b1, 1'b0});
      end
      checks++;
      if ({wb_adr_o, wb_sel_o, wb_dat_o} !== {a, exp_sel, wd}) begin
         errors++;
         $display("[TB] FAIL %s bus_fields got %h/%h/%h expected %h/%h/%h", tag,
                  wb_adr_o, wb_sel_o, wb_dat_o, a, exp_sel, wd);
      end
      for (int i = 0; i < delay; i++) begin
         wb_dat_i = $urandom;
         @(negedge clk_i);
         checks++;
         if ({wb_cyc_o, ready_o, wb_adr_o, wb_sel_o, wb_dat_o} !== {1'b1, 1'b0, a, exp_sel, wd}) begin
            errors++;
            $display("[TB] FAIL %s hold got cyc=%b rdy=%b adr=%h sel=%h expected cyc=1 rdy=0 adr=%h sel=%h",
                     tag, wb_cyc_o, ready_o, wb_adr_o, wb_sel_o, a, exp_sel);
         end
      end
      wb_ack_i = ack; wb_err_i = er; wb_dat_i = rd;
      @(negedge clk_i);
      wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_dat_i = $urandom;
      checks++;
      if ({ready_o, err_o, wb_cyc_o, wb_stb_o, busy_o} !== {1'b1, er, 1'b0, 1'b0, 1'b1}) begin
         errors++;
         $display("[TB] FAIL %s resp_ctrl got %b expected %b", tag,
                  {ready_o, err_o, wb_cyc_o, wb_stb_o, busy_o}, {1'b1, er, 1'b0, 1'b0, 1'b1});
      end
      checks++;
      if (rdata_o !== exp_rdata) begin
         errors++;
         $display("[TB] FAIL %s rdata got %h expected %h", tag, rdata_o, exp_rdata);
      end
      @(negedge clk_i);
      valid_i = 1'b0;
      checks++;
      if ({ready_o, err_o, busy_o, wb_cyc_o, rdata_o} !== 36'h0) begin
         errors++;
         $display("[TB] FAIL %s idle_after got rdy=%b err=%b busy=%b cyc=%b rdata=%h expected all 0",
                  tag, ready_o, err_o, busy_o, wb_cyc_o, rdata_o);
      end
   endtask

   // Outputs are zero under reset and after its release.
   task automatic test_reset();
      arst_i = 1'b1; valid_i = 1'b0; addr_i = '0; wdata_i = '0; wstrb_i = '0;
      wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_dat_i = '0;
      repeat (3) @(negedge clk_i);
      checks++;
      if ({rdata_o, ready_o, err_o, busy_o, wb_adr_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o, wb_dat_o} !== '0) begin
         errors++;
         $display("[TB] FAIL reset_outputs got nonzero (cyc=%b busy=%b adr=%h) expected 0",
                  wb_cyc_o, busy_o, wb_adr_o);
      end
      arst_i = 1'b0;
      @(negedge clk_i);
      checks++;
      if ({ready_o, busy_o, wb_cyc_o} !== 3'b000) begin
         errors++;
         $display("[TB] FAIL reset_release got %b expected 000", {ready_o, busy_o, wb_cyc_o});
      end
   endtask

   // Fixed directed cases: write, single-byte read, ack+err together.
   task automatic test_directed();
      do_transfer("write", 32'h10, 32'hDEADBEEF, 4'h3, 1, 1'b1, 1'b0, 32'h12345678, 1'b0);
      do_transfer("read_b3", 32'h13, 32'h0, 4'h0, 0, 1'b1, 1'b0, 32'hA5000000, 1'b0);
      do_transfer("ack_err", 32'h20, 32'h0, 4'h0, 2, 1'b1, 1'b1, 32'h0BADF00D, 1'b0);
      do_transfer("err_only", 32'h44, 32'h55AA55AA, 4'hF, 0, 1'b0, 1'b1, 32'h1, 1'b0);
   endtask

   // Chained transfers with valid held high while busy.
   task automatic test_back_to_back();
      do_transfer("b2b_0", 32'h100, 32'h11111111, 4'h0, 0, 1'b1, 1'b0, 32'hCAFE0001, 1'b1);
      do_transfer("b2b_1", 32'h101, 32'h22222222, 4'hC, 1, 1'b1, 1'b0, 32'hCAFE0002, 1'b1);
      do_transfer("b2b_2", 32'h102, 32'h33333333, 4'h0, 3, 1'b1, 1'b0, 32'hCAFE0003, 1'b0);
   endtask

   // Ack/err seen while IDLE must not start or finish anything.
   task automatic test_ignore_idle();
      int bad;
      bad = 0;
      for (int i = 0; i < 4; i++) begin
         wb_ack_i = i[0]; wb_err_i = i[1]; wb_dat_i = $urandom;
         @(negedge clk_i);
         if (ready_o || busy_o || wb_cyc_o) bad++;
      end
      wb_ack_i = 1'b0; wb_err_i = 1'b0;
      checks++;
      if (bad !== 0) begin
         errors++;
         $display("[TB] FAIL ignore_idle got %0d active cycles expected 0", bad);
      end
   endtask

   // Random reads/writes with random latency and response kind.
   task automatic test_random();
      for (int n = 0; n < 40; n++) begin
         logic [3:0] ws;
         logic ack, er;
         ws  = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
         er  = ($urandom_range(0, 3) == 0);
         ack = er ? 1'($urandom_range(0, 1)) : 1'b1;
         do_transfer("random", $urandom, $urandom, ws, $urandom_range(0, 5), ack, er,
                     $urandom, 1'($urandom_range(0, 1)));
      end
   endtask

   // Silent slave: watchdog fires after 2**TW-1 BUS cycles, or cycle is held.
   task automatic test_timeout();
      int n;
      valid_i = 1'b1; addr_i = 32'h200; wstrb_i = 4'h0; wdata_i = $urandom;
      @(negedge clk_i);
      valid_i = 1'b0;
      n = 0;
`ifdef IOB_WB_BRIDGE_TIMEOUT_EN
      while (wb_cyc_o && n < 300) begin
         wb_dat_i = $urandom;
         n++;
         @(negedge clk_i);
      end
      checks++;
      if (n !== (2 ** TW) - 1) begin
         errors++;
         $display("[TB] FAIL timeout_cycles got %0d expected %0d", n, (2 ** TW) - 1);
      end
      checks++;
      if ({ready_o, err_o, rdata_o} !== {1'b1, 1'b1, 32'h0}) begin
         errors++;
         $display("[TB] FAIL timeout_resp got rdy=%b err=%b rdata=%h expected 1 1 0",
                  ready_o, err_o, rdata_o);
      end
      @(negedge clk_i);
`else
      for (int i = 0; i < 120; i++) begin
         if (!wb_cyc_o || ready_o) n++;
         wb_dat_i = $urandom;
         @(negedge clk_i);
      end
      checks++;
      if (n !== 0) begin
         errors++;
         $display("[TB] FAIL no_timeout got %0d dropped cycles expected 0", n);
      end
      wb_ack_i = 1'b1; wb_dat_i = 32'h77;
      @(negedge clk_i);
      wb_ack_i = 1'b0;
      checks++;
      if ({ready_o, err_o, rdata_o} !== {1'b1, 1'b0, 32'h77}) begin
         errors++;
         $display("[TB] FAIL late_ack got rdy=%b err=%b rdata=%h expected 1 0 77",
                  ready_o, err_o, rdata_o);
      end
      @(negedge clk_i);
`endif
      checks++;
      if ({ready_o, busy_o, wb_cyc_o} !== 3'b000) begin
         errors++;
         $display("[TB] FAIL timeout_idle got %b expected 000", {ready_o, busy_o, wb_cyc_o});
      end
   endtask

   // Asynchronous reset during BUS abandons the transfer without a response.
   task automatic test_reset_mid_bus();
      int seen;
      valid_i = 1'b1; addr_i = 32'h300; wstrb_i = 4'hF; wdata_i = 32'hFEEDFACE;
      @(negedge clk_i);
      valid_i = 1'b0;
      @(negedge clk_i);
      arst_i = 1'b1;
      #1;
      checks++;
      if ({wb_cyc_o, wb_stb_o, ready_o, busy_o} !== 4'b0000) begin
         errors++;
         $display("[TB] FAIL reset_mid_bus got %b expected 0000", {wb_cyc_o, wb_stb_o, ready_o, busy_o});
      end
      @(negedge clk_i);
      arst_i = 1'b0;
      seen = 0;
      for (int i = 0; i < 5; i++) begin
         wb_ack_i = (i == 1);
         @(negedge clk_i);
         if (ready_o || wb_cyc_o) seen++;
      end
      wb_ack_i = 1'b0;
      checks++;
      if (seen !== 0) begin
         errors++;
         $display("[TB] FAIL reset_no_resp got %0d active cycles expected 0", seen);
      end
      do_transfer("after_reset", 32'h304, 32'h0, 4'h0, 1, 1'b1, 1'b0, 32'h600DDA7A, 1'b0);
   endtask

   initial begin
      test_reset();
      test_directed();
      test_back_to_back();
      test_ignore_idle();
      test_random();
      test_timeout();
      test_reset_mid_bus();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Hard time bound so the bench can never hang.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog_time got timeout expected completion");
      $fatal(1, "[TB] simulation time limit reached");
   end

endmodule
